// File: rtl/divider_32bit.sv
// Iterative restoring divider with RV32M DIV/DIVU/REM/REMU semantics.
// One trial-subtraction step per clock; special cases finish in one cycle.
module divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state_q;
  logic        [CNT_W-1:0]   cnt_q;
  logic        [WIDTH-1:0]   rem_q, rem_d;
  logic        [WIDTH-1:0]   dvd_q, dvd_d;
  logic        [WIDTH-1:0]   dsr_q;
  logic                      qneg_q, rneg_q;
  logic signed [WIDTH-1:0]   a_s, b_s;
  logic        [WIDTH:0]     shf, diff;
  logic        [WIDTH-1:0]   a_abs, b_abs;
  logic                      a_neg, b_neg, b_zero, ovf;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    a_s    = a_i;
    b_s    = b_i;
    a_neg  = signed_i && (a_s < 0);
    b_neg  = signed_i && (b_s < 0);
    b_zero = (b_i == '0);
    ovf    = signed_i && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
    a_abs  = cond_neg(a_i, a_neg);
    b_abs  = cond_neg(b_i, b_neg);
    // Remainder stays below the divisor, so WIDTH bits hold it; the shifted
    // value needs one more bit and the difference's MSB is the borrow.
    shf    = {rem_q, dvd_q[WIDTH-1]};
    diff   = shf - {1'b0, dsr_q};
    rem_d  = diff[WIDTH] ? shf[WIDTH-1:0] : diff[WIDTH-1:0];
    dvd_d  = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  // Control and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      q_o        <= '0;
      r_o        <= '0;
      div_zero_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_o <= 1'b0;
          if (start_i) begin
            if (b_zero) begin
              q_o        <= '1;
              r_o        <= a_i;
              div_zero_o <= 1'b1;
              valid_o    <= 1'b1;
              state_q    <= DONE;
            end else if (ovf) begin
              q_o        <= a_i;
              r_o        <= '0;
              div_zero_o <= 1'b0;
              valid_o    <= 1'b1;
              state_q    <= DONE;
            end else begin
              cnt_q   <= CNT_W'(WIDTH - 1);
              busy_o  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt_q == '0) begin
            q_o        <= cond_neg(dvd_d, qneg_q);
            r_o        <= cond_neg(rem_d, rneg_q);
            div_zero_o <= 1'b0;
            busy_o     <= 1'b0;
            valid_o    <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          valid_o <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: operand capture and one restoring step per cycle
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && start_i) begin
      rem_q  <= '0;
      dvd_q  <= a_abs;
      dsr_q  <= b_abs;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
    end else if (state_q == CALC) begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
    end
  end

endmodule
